// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU; logic/add/shift ops in one cycle, MULU/DIVU iterate one bit per cycle.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             zero,
  output logic             err
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, ITER} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] acc, lo, b, add_r, sub_r, rot, s_res, n_acc, n_lo;
  logic [WIDTH:0] sum, sh, diff;
  logic [SHW-1:0] amt;
  logic is_div, accept, multi, s_ovf, s_err;
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept = in_valid && in_ready;
  assign multi = (op == 4'd10) || (op == 4'd11);
  assign zero = (result == '0);
  assign amt = src2[SHW-1:0];
  assign add_r = src1 + src2;
  assign sub_r = src1 - src2;
  assign rot = WIDTH'({src1, src1} >> amt);
  always_comb begin
    s_res = '0;
    s_ovf = 1'b0;
    s_err = 1'b0;
    case (op)
      4'd0: begin
        s_res = add_r;
        s_ovf = (src1[WIDTH-1] == src2[WIDTH-1]) && (add_r[WIDTH-1] != src1[WIDTH-1]);
      end
      4'd1: begin
        s_res = sub_r;
        s_ovf = (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_r[WIDTH-1] != src1[WIDTH-1]);
      end
      4'd2: s_res = src1 & src2;
      4'd3: s_res = src1 | src2;
      4'd4: s_res = src1 ^ src2;
      4'd5: s_res = src1 >> amt;
      4'd6: s_res = src1 << amt;
      4'd7: s_res = rot;
      4'd8: s_res = $signed(src1) >>> amt;
      4'd9: s_res = src1;
      4'd10, 4'd11: s_err = 1'b0;
      default: s_err = 1'b1;
    endcase
  end
  // acc/lo form the double-width shift register: product (hi,lo) or remainder/quotient
  assign sum = {1'b0, acc} + (lo[0] ? {1'b0, b} : '0);
  assign sh = {acc, lo[WIDTH-1]};
  assign diff = sh - {1'b0, b};
  assign n_acc = is_div ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
  assign n_lo = is_div ? {lo[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo[WIDTH-1:1]};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      out_valid <= 1'b0;
      result <= '0;
      result_hi <= '0;
      overflow <= 1'b0;
      err <= 1'b0;
      acc <= '0;
      lo <= '0;
      b <= '0;
      is_div <= 1'b0;
    end else if (state == IDLE) begin
      if (accept && !multi) begin
        out_valid <= 1'b1;
        result <= s_res;
        result_hi <= '0;
        overflow <= s_ovf;
        err <= s_err;
      end else if (accept) begin
        out_valid <= 1'b0;
        state <= ITER;
        cnt <= CW'(WIDTH);
        acc <= '0;
        lo <= src1;
        b <= src2;
        is_div <= op[0];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end else begin
      acc <= n_acc;
      lo <= n_lo;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state <= IDLE;
        out_valid <= 1'b1;
        result <= n_lo;
        result_hi <= n_acc;
        overflow <= is_div && (b == '0);
        err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc at WIDTH=32.
module tb_alu_mc;
  logic clk = 0, reset_n = 0, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [3:0] op = 0;
  logic [31:0] src1 = 0, src2 = 0, result, result_hi;
  logic overflow, zero, err;
  int n_checks = 0, n_errors = 0;
  typedef struct packed {logic [31:0] res; logic [31:0] hi; logic ovf; logic err;} exp_t;
  exp_t sb[$];
  alu_mc #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .overflow(overflow), .zero(zero), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] bb);
    exp_t e;
    logic [32:0] t;
    logic [63:0] p;
    logic [31:0] r;
    int s;
    e = '0;
    s = int'(bb[4:0]);
    r = a;
    case (o)
      4'd0: begin
        t = {1'b0, a} + {1'b0, bb};
        e.res = t[31:0];
        e.ovf = (a[31] == bb[31]) && (e.res[31] != a[31]);
      end
      4'd1: begin
        e.res = a - bb;
        e.ovf = (a[31] != bb[31]) && (e.res[31] != a[31]);
      end
      4'd2: e.res = a & bb;
      4'd3: e.res = a | bb;
      4'd4: e.res = a ^ bb;
      4'd5: e.res = a >> s;
      4'd6: e.res = a << s;
      4'd7: begin
        repeat (s) r = {r[0], r[31:1]};
        e.res = r;
      end
      4'd8: begin
        repeat (s) r = {r[31], r[31:1]};
        e.res = r;
      end
      4'd9: e.res = a;
      4'd10: begin
        p = {32'd0, a} * {32'd0, bb};
        e.res = p[31:0];
        e.hi = p[63:32];
      end
      4'd11: begin
        if (bb == 0) begin
          e.res = 32'hFFFF_FFFF;
          e.hi = a;
          e.ovf = 1'b1;
        end else begin
          e.res = a / bb;
          e.hi = a % bb;
        end
      end
      default: e.err = 1'b1;
    endcase
    return e;
  endfunction
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("result_hi", result_hi, e.hi);
        check("overflow", overflow, e.ovf);
        check("err", err, e.err);
        check("zero", zero, e.res == 0);
      end
    end
  end
  task automatic send(input logic [3:0] o, input logic [31:0] a, input logic [31:0] bb);
    int n;
    n = 0;
    op = o;
    src1 = a;
    src2 = bb;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(posedge clk);
      #1 out_ready = 1;
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    else sb.push_back(model(o, a, bb));
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
  endtask
  initial begin
    int n;
    logic bad;
    exp_t e;
    #2;
    check("rst_result", result, 0);
    check("rst_hi", result_hi, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_err", err, 0);
    check("rst_zero", zero, 1);
    @(negedge clk) reset_n = 1;
    @(posedge clk);
    #1 out_ready = 1;
    send(4'd0, 32'h7FFF_FFFF, 32'h1);
    check("add_lat", out_valid, 1);
    send(4'd1, 32'd5, 32'd5);
    send(4'd7, 32'h1, 32'hFFFF_FFE1);
    send(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n = 0;
    bad = 0;
    while (!out_valid && n < 100) begin
      if (in_ready) bad = 1;
      @(posedge clk);
      #1 n++;
    end
    check("mul_lat", n + 1, 33);
    check("ready_iter", bad, 0);
    send(4'd11, 32'd100, 32'd7);
    send(4'd11, 32'd9, 32'd0);
    drain();
    out_ready = 0;
    send(4'd0, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_result", result, 7);
      check("stall_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1;
    send(4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF);
    check("xor_valid", out_valid, 1);
    check("xor_result", result, 32'hFF00_EDCB);
    send(4'd6, 32'h1234_5678, 32'hFFFF_FFE0);
    send(4'd8, 32'h8000_0010, 32'd4);
    send(4'd5, 32'h8000_0010, 32'd31);
    send(4'd9, 32'hCAFE_BABE, 32'd0);
    send(4'd12, 32'd1, 32'd1);
    send(4'd15, 32'd7, 32'd7);
    send(4'd11, 32'hDEAD_BEEF, 32'd1);
    send(4'd10, 32'd0, 32'hFFFF_FFFF);
    send(4'd1, 32'h8000_0000, 32'd1);
    for (int i = 0; i < 40; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send(4'($urandom_range(0, 15)), $urandom, $urandom);
    end
    out_ready = 1;
    send(4'd9, 32'h1234, 32'd0);
    drain();
    send(4'd10, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (8) @(posedge clk);
    #2 reset_n = 0;
    #1;
    sb.delete();
    check("mid_rst_result", result, 0);
    check("mid_rst_hi", result_hi, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_zero", zero, 1);
    @(negedge clk) reset_n = 1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (out_valid) bad = 1;
    end
    check("no_result_after_rst", bad, 0);
    send(4'd13, 32'h55, 32'hAA);
    check("illegal_err", err, 1);
    check("illegal_result", result, 0);
    drain();
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (legal 8..64, power of two).
REQ-002 The block SHALL have parameter SHW, default clog2(WIDTH), meaning the shift-amount field width.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  command valid
- in_ready  output  1  command accepted when in_valid && in_ready
- op  input  4  operation code, REQ-006
- src1  input  WIDTH  operand 1
- src2  input  WIDTH  operand 2
- out_valid  output  1  result registers hold an unconsumed result
- out_ready  input  1  consumer accepts result when out_valid && out_ready
- result  output  WIDTH  low/primary result
- result_hi  output  WIDTH  MUL high word / DIVU remainder; 0 for other ops
- overflow  output  1  signed overflow (ADD/SUB) or divide-by-zero (DIVU)
- zero  output  1  result == 0 (low word only)
- err  output  1  illegal op code

Function
REQ-004 The block SHALL contain FSM states IDLE and ITER; reset state is IDLE.
REQ-005 in_ready SHALL be 1 only in IDLE and when (!out_valid || out_ready).
REQ-006 Op codes SHALL be: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SRL, 6 SLL, 7 ROTR, 8 SRA, 9 MOV (result=src1), 10 MULU, 11 DIVU; 12-15 illegal.
REQ-007 Single-cycle ops (0-9, illegal) SHALL load result registers on the accept edge; out_valid=1 the next cycle (latency 1); FSM stays IDLE.
REQ-008 ADD/SUB SHALL compute modulo 2^WIDTH; overflow = two's-complement signed overflow; logic/shift/MOV ops SHALL drive overflow=0.
REQ-009 Shifts/rotate SHALL use src2[SHW-1:0] only; upper src2 bits ignored; amount 0 returns src1 unchanged; SRA replicates src1[WIDTH-1].
REQ-010 Illegal op SHALL return result=0, result_hi=0, overflow=0, err=1; err=0 for all legal ops.
REQ-011 MULU/DIVU SHALL latch operands on accept, enter ITER, and iterate one bit per cycle for exactly WIDTH cycles (shift-add multiply; restoring divide) using a down-counter of clog2(WIDTH)+1 bits.
REQ-012 On the last ITER cycle the block SHALL load result registers and return to IDLE; out_valid=1 exactly WIDTH+1 cycles after accept.
REQ-013 MULU SHALL give {result_hi,result} = unsigned 2*WIDTH-bit product; overflow=0.
REQ-014 DIVU SHALL give result=quotient, result_hi=remainder; if src2==0: result=all ones, result_hi=src1, overflow=1 (still WIDTH+1 latency).
REQ-015 Result registers and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-016 Consume-and-accept in the same cycle SHALL be legal: out_valid stays 1 (single-cycle op) or drops to 0 (MULU/DIVU) next cycle.
REQ-017 out_valid SHALL clear on out_ready when no new single-cycle result loads that edge.
REQ-018 in_valid while in_ready=0 SHALL be ignored (no queueing); src/op need only be valid on the accept edge.
REQ-019 zero SHALL be derived combinationally from the result register.

Reset
REQ-020 reset_n low SHALL asynchronously force: FSM=IDLE, counter=0, out_valid=0, result=0, result_hi=0, overflow=0, err=0; zero therefore reads 1.
REQ-021 Reset asserted mid-ITER SHALL abandon the operation with no result produced; first accept is legal on the first rising edge after reset_n deasserts.

Verification (WIDTH=32)
REQ-022 ADD 0x7FFFFFFF+0x00000001, out_ready=1 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0.
REQ-023 SUB 5-5 then ROTR 0x00000001 by src2=0xFFFFFFE1 -> result 0/zero=1/overflow=0; then result 0x80000000 (amount 1).
REQ-024 MULU 0xFFFFFFFF*0xFFFFFFFF -> out_valid at accept+33 cycles, result=0x00000001, result_hi=0xFFFFFFFE; in_ready=0 throughout ITER.
REQ-025 DIVU 100/7 -> result=14, result_hi=2; DIVU 9/0 -> result=0xFFFFFFFF, result_hi=9, overflow=1.
REQ-026 out_ready held 0 for 5 cycles after ADD result -> outputs stable, in_ready=0; then out_ready=1 with new XOR in_valid same cycle -> accepted, XOR result next cycle.
REQ-027 reset_n pulsed low during cycle 10 of a MULU -> all outputs 0 immediately, no out_valid afterwards; op 13 after reset -> result=0, err=1.
